// File: rtl/link_pkg.sv
// Shared state encodings and constants for the burst link master and slave.
package link_pkg;

  typedef enum logic [1:0] {
    M_IDLE,
    M_REQ,
    M_DROP,
    M_DONE
  } master_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } slave_state_t;

  localparam int ACK_DELAY_W = 4;

endpackage

// File: rtl/link_slave_acc.sv
// Burst link slave: waits a programmable delay before acking, and on each ack
// captures the word into last-word, running checksum and word-count registers.
module link_slave_acc
  import link_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int BURST_LEN = 4,
  parameter  int ACK_DELAY = 0,
  localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_last_word,
  output logic [DATA_W-1:0] o_checksum,
  output logic [CNT_W-1:0]  o_word_cnt
);

  slave_state_t           r_state;
  logic [ACK_DELAY_W-1:0] r_cnt;
  logic [DATA_W-1:0]      r_last_word;
  logic [DATA_W-1:0]      r_checksum;
  logic [CNT_W-1:0]       r_word_cnt;

  // Capture happens on the transition into S_ACK; clr only arrives while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_word <= '0;
      r_checksum  <= '0;
      r_word_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            if (ACK_DELAY > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= '0;
            end else begin
              r_state     <= S_ACK;
              r_last_word <= i_data;
              r_checksum  <= r_checksum + i_data;
              r_word_cnt  <= r_word_cnt + CNT_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == ACK_DELAY_W'(ACK_DELAY - 1)) begin
            r_state     <= S_ACK;
            r_last_word <= i_data;
            r_checksum  <= r_checksum + i_data;
            r_word_cnt  <= r_word_cnt + CNT_W'(1);
          end else begin
            r_cnt <= r_cnt + ACK_DELAY_W'(1);
          end
        end
        S_ACK: begin
          if (!i_req) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (i_clr) begin
        r_checksum <= '0;
        r_word_cnt <= '0;
      end
    end
  end

  assign o_ack       = (r_state == S_ACK);
  assign o_last_word = r_last_word;
  assign o_checksum  = r_checksum;
  assign o_word_cnt  = r_word_cnt;

endmodule

// File: rtl/link_burst_top.sv
// Burst link top: inline master FSM sending BURST_LEN words over a 4-phase
// req/ack handshake to link_slave_acc, with registered status/monitor outputs.
module link_burst_top
  import link_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int BURST_LEN = 4,
  parameter  int START_VAL = 1,
  parameter  int STEP      = 1,
  parameter  int ACK_DELAY = 0,
  localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              req_mon,
  output logic              ack_mon,
  output logic [DATA_W-1:0] last_word,
  output logic [DATA_W-1:0] checksum,
  output logic [CNT_W-1:0]  word_cnt
);

  master_state_t     r_state;
  logic [CNT_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_busy;
  logic              r_done;
  logic              r_req_mon;
  logic              r_ack_mon;
  logic              w_req;
  logic              w_ack;
  logic              w_accept;

  assign w_req    = (r_state == M_REQ);
  assign w_accept = (r_state == M_IDLE) && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= M_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        M_IDLE: begin
          if (start) begin
            r_state <= M_REQ;
            r_idx   <= '0;
            r_data  <= DATA_W'(START_VAL);
          end
        end
        M_REQ: begin
          if (w_ack) r_state <= M_DROP;
        end
        M_DROP: begin
          if (!w_ack) begin
            if (r_idx == CNT_W'(BURST_LEN - 1)) begin
              r_state <= M_DONE;
            end else begin
              r_state <= M_REQ;
              r_idx   <= r_idx + CNT_W'(1);
              r_data  <= r_data + DATA_W'(STEP);
            end
          end
        end
        M_DONE:  r_state <= M_IDLE;
        default: r_state <= M_IDLE;
      endcase
    end
  end

  // Status and monitor outputs are registered copies, one cycle behind the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_req_mon <= 1'b0;
      r_ack_mon <= 1'b0;
    end else begin
      r_busy    <= (r_state != M_IDLE);
      r_done    <= (r_state == M_DONE);
      r_req_mon <= w_req;
      r_ack_mon <= w_ack;
    end
  end

  link_slave_acc #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN),
    .ACK_DELAY (ACK_DELAY)
  ) u_slave (
    .clk         (clk),
    .rst_n       (rst),
    .i_clr       (w_accept),
    .i_req       (w_req),
    .i_data      (r_data),
    .o_ack       (w_ack),
    .o_last_word (last_word),
    .o_checksum  (checksum),
    .o_word_cnt  (word_cnt)
  );

  assign busy    = r_busy;
  assign done    = r_done;
  assign req_mon = r_req_mon;
  assign ack_mon = r_ack_mon;

endmodule

// File: tb/tb_link_burst_top.sv
// Bench for link_burst_top: three instances (default, ACK_DELAY=2, START_VAL=FE)
// checked every cycle against a timeline model derived from burst timing rules.
module tb_link_burst_top;

  localparam int NI = 3;
  localparam int B  = 4;
  localparam int DLY  [NI] = '{0, 2, 0};
  localparam int SVAL [NI] = '{1, 1, 254};

  typedef struct packed {
    logic       req;
    logic       ack;
    logic       busy;
    logic       done;
    logic [7:0] last;
    logic [7:0] cs;
    logic [2:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] st;
  logic [2:0] busyV, doneV, reqV, ackV;
  logic [7:0] lastV [NI];
  logic [7:0] csV   [NI];
  logic [2:0] cntV  [NI];

  int         checks;
  int         errors;
  int         edgeNo;
  int         acc      [NI];
  bit         has      [NI];
  logic [7:0] prevLast [NI];

  always #5 clk = ~clk;

  link_burst_top #(.DATA_W(8), .BURST_LEN(4), .START_VAL(1), .STEP(1), .ACK_DELAY(0)) dutA (
    .clk(clk), .rst(rst), .start(st[0]), .busy(busyV[0]), .done(doneV[0]),
    .req_mon(reqV[0]), .ack_mon(ackV[0]), .last_word(lastV[0]), .checksum(csV[0]),
    .word_cnt(cntV[0])
  );

  link_burst_top #(.DATA_W(8), .BURST_LEN(4), .START_VAL(1), .STEP(1), .ACK_DELAY(2)) dutB (
    .clk(clk), .rst(rst), .start(st[1]), .busy(busyV[1]), .done(doneV[1]),
    .req_mon(reqV[1]), .ack_mon(ackV[1]), .last_word(lastV[1]), .checksum(csV[1]),
    .word_cnt(cntV[1])
  );

  link_burst_top #(.DATA_W(8), .BURST_LEN(4), .START_VAL(254), .STEP(1), .ACK_DELAY(0)) dutC (
    .clk(clk), .rst(rst), .start(st[2]), .busy(busyV[2]), .done(doneV[2]),
    .req_mon(reqV[2]), .ack_mon(ackV[2]), .last_word(lastV[2]), .checksum(csV[2]),
    .word_cnt(cntV[2])
  );

  // Expected outputs k edges after the accepting edge: each word occupies
  // 4+D cycles, visible outputs lag the handshake by one cycle, and a word is
  // captured 1+D edges after its req phase begins.
  function automatic exp_t model(input int i, input int k);
    exp_t       e;
    int         d, p, n;
    logic [7:0] s;
    d      = DLY[i];
    p      = 4 + d;
    e      = '0;
    e.last = prevLast[i];
    if (!has[i]) return e;
    n = (k >= 1 + d) ? (k - 1 - d) / p + 1 : 0;
    if (n > B) n = B;
    s = 8'h00;
    for (int w = 0; w < n; w++) s = s + 8'(SVAL[i] + w);
    e.cs  = s;
    e.cnt = 3'(n);
    if (n > 0) e.last = 8'(SVAL[i] + n - 1);
    e.req  = (k >= 1) && (k <= B * p) && (((k - 1) % p) <= 1 + d);
    e.ack  = (k >= 2 + d) && (((k - 2 - d) / p) < B) && (((k - 2 - d) % p) <= 1);
    e.busy = (k >= 1) && (k <= B * p + 1);
    e.done = (k == B * p + 1);
    return e;
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      e = model(i, edgeNo - acc[i]);
      chk("req_mon",   i, reqV[i],  e.req);
      chk("ack_mon",   i, ackV[i],  e.ack);
      chk("busy",      i, busyV[i], e.busy);
      chk("done",      i, doneV[i], e.done);
      chk("last_word", i, lastV[i], e.last);
      chk("checksum",  i, csV[i],   e.cs);
      chk("word_cnt",  i, cntV[i],  e.cnt);
    end
  endtask

  // Drive start at the falling edge, apply the acceptance rule at the rising
  // edge (idle means at least 4*(4+D)+2 edges since the previous accept), check
  // at the next falling edge.
  task automatic applyStimulus(input logic [2:0] s);
    exp_t old;
    st = s;
    @(posedge clk);
    edgeNo++;
    for (int i = 0; i < NI; i++) begin
      if (rst && s[i] && (!has[i] || (edgeNo - acc[i] >= B * (4 + DLY[i]) + 2))) begin
        if (has[i]) begin
          old         = model(i, edgeNo - acc[i]);
          prevLast[i] = old.last;
        end
        acc[i] = edgeNo;
        has[i] = 1'b1;
      end
    end
    @(negedge clk);
    checkOutput();
  endtask

  // Random start pulses only while an instance should ignore them.
  function automatic logic [2:0] garbage();
    logic [2:0] g;
    int         k;
    g = '0;
    for (int i = 0; i < NI; i++) begin
      k = edgeNo - acc[i];
      if (has[i] && k >= 0 && k <= B * (4 + DLY[i])) g[i] = 1'($urandom_range(0, 1));
    end
    return g;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < NI; i++) begin
      has[i]      = 1'b0;
      acc[i]      = 0;
      prevLast[i] = 8'h00;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edgeNo = 0;
    st     = '0;
    clearModel();
    rst = 1'b1;
    #1 rst = 1'b0;

    repeat (4) applyStimulus(3'($urandom));
    rst = 1'b1;
    repeat (5) applyStimulus(3'b000);

    applyStimulus(3'b111);
    repeat (28) applyStimulus(garbage());
    chk("final_cs",   0, csV[0],   8'h0A);
    chk("final_last", 0, lastV[0], 8'h04);
    chk("final_cnt",  0, cntV[0],  3'd4);
    chk("final_cs",   1, csV[1],   8'h0A);
    chk("final_cs",   2, csV[2],   8'hFE);
    chk("final_last", 2, lastV[2], 8'h01);

    repeat (2) begin
      repeat ($urandom_range(0, 4)) applyStimulus(3'b000);
      applyStimulus(3'b111);
      repeat (28) applyStimulus(garbage());
    end

    repeat (44) applyStimulus(3'b001);
    repeat (28) applyStimulus(3'b000);
    chk("held_cs", 0, csV[0], 8'h0A);

    applyStimulus(3'b111);
    repeat (5) applyStimulus(3'b000);
    chk("pre_reset_req", 0, reqV[0], 1'b1);
    #2 rst = 1'b0;
    clearModel();
    #1 checkOutput();
    @(negedge clk);
    repeat (2) applyStimulus(3'b000);
    rst = 1'b1;
    applyStimulus(3'b111);
    repeat (28) applyStimulus(garbage());
    chk("post_reset_cs", 0, csV[0], 8'h0A);
    chk("post_reset_cs", 1, csV[1], 8'h0A);
    chk("post_reset_cs", 2, csV[2], 8'hFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
